// File: rtl/regfile_wr_sched_if.sv
// Writeback request bus: NREQ requesters offering (rd, wd) to the regfile write scheduler.
// master = requester side, slave = scheduler side.
interface regfile_wr_sched_if #(
  parameter int unsigned NREQ = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [5*NREQ-1:0]  req_rd;
  logic [32*NREQ-1:0] req_wd;
  logic [NREQ-1:0]    req_ready;

  modport master (
    output req_valid,
    output req_rd,
    output req_wd,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rd,
    input  req_wd,
    output req_ready
  );
endinterface

// File: rtl/regfile_wr_sched.sv
// Owner of the integer regfile write port: clears x1..x31 after reset, then arbitrates writebacks.
// Optional macro RF_SCHED_FIXED_PRIO_EN selects fixed priority (lowest index) instead of round-robin.
module regfile_wr_sched #(
  parameter int unsigned NREQ    = 3,
  parameter logic [31:0] SP_INIT = 32'h3FBFC,
  parameter logic [31:0] BP_INIT = 32'h3FBFC
) (
  input  logic                CLK,
  input  logic                RST,
  regfile_wr_sched_if.slave   req,
  output logic                rf_we,
  output logic [4:0]          rf_rd,
  output logic [31:0]         rf_wd,
  output logic                init_done
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {StClear, StRun} state_t;

  state_t            state_q;
  logic [4:0]        idx_q;
  logic [PtrW-1:0]   rr_ptr;
  logic [NREQ-1:0]   gnt;
  logic              gnt_any;
  logic [4:0]        sel_rd;
  logic [31:0]       sel_wd;

`ifdef RF_SCHED_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [PtrW-1:0]   rr_ptr_q;
  logic [PtrW-1:0]   gnt_idx;
  assign rr_ptr = rr_ptr_q;
`endif

  // Two passes: first requesters at or above rr_ptr, then wrap to the lowest index.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    sel_rd  = '0;
    sel_wd  = '0;
`ifndef RF_SCHED_FIXED_PRIO_EN
    gnt_idx = '0;
`endif
    if (state_q == StRun) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!gnt_any && req.req_valid[i] && (i >= int'(rr_ptr))) begin
          gnt[i]  = 1'b1;
          gnt_any = 1'b1;
          sel_rd  = req.req_rd[5*i +: 5];
          sel_wd  = req.req_wd[32*i +: 32];
`ifndef RF_SCHED_FIXED_PRIO_EN
          gnt_idx = PtrW'(i);
`endif
        end
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!gnt_any && req.req_valid[i]) begin
          gnt[i]  = 1'b1;
          gnt_any = 1'b1;
          sel_rd  = req.req_rd[5*i +: 5];
          sel_wd  = req.req_wd[32*i +: 32];
`ifndef RF_SCHED_FIXED_PRIO_EN
          gnt_idx = PtrW'(i);
`endif
        end
      end
    end
  end

  assign req.req_ready = gnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StClear;
      idx_q     <= 5'd1;
`ifndef RF_SCHED_FIXED_PRIO_EN
      rr_ptr_q  <= '0;
`endif
      rf_we     <= 1'b0;
      rf_rd     <= '0;
      rf_wd     <= '0;
      init_done <= 1'b0;
    end else begin
      case (state_q)
        StClear: begin
          rf_we <= 1'b1;
          rf_rd <= idx_q;
          rf_wd <= (idx_q == 5'd2) ? SP_INIT :
                   (idx_q == 5'd8) ? BP_INIT : 32'd0;
          idx_q <= idx_q + 5'd1;
          if (idx_q == 5'd31) begin
            state_q   <= StRun;
            init_done <= 1'b1;
          end
        end
        StRun: begin
          if (gnt_any) begin
            // A request to x0 is consumed but never reaches the regfile.
            rf_we <= (sel_rd != 5'd0);
            rf_rd <= sel_rd;
            rf_wd <= sel_wd;
`ifndef RF_SCHED_FIXED_PRIO_EN
            rr_ptr_q <= (gnt_idx == PtrW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
          end else begin
            rf_we <= 1'b0;
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Scoreboard bench for regfile_wr_sched: stimulus pushes expected regfile writes, a monitor pops them.
module tb_regfile_wr_sched;
  localparam int N = 3;
  localparam logic [31:0] INIT_VAL = (32'hff00 - 1) << 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        init_done;

  regfile_wr_sched_if #(.NREQ(N)) bus ();

  regfile_wr_sched #(.NREQ(N)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (bus),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .init_done (init_done)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad   = 0;
  wr_t         exp_q[$];
  logic [31:0] rf_arr   [32];
  logic [31:0] model_rf [32];
  int          rr = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endfunction

  // Regfile fed by the DUT, committing on the negedge.
  always @(negedge CLK) if (rf_we) rf_arr[rf_rd] <= rf_wd;

  // Monitor: every DUT write must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge CLK);
      if (rf_we === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got rd=%0d wd=%0h want no write", rf_rd, rf_wd);
        end else begin
          e = exp_q.pop_front();
          check("write_rd", rf_rd, e.rd);
          check("write_wd", rf_wd, e.wd);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference arbitration: first valid requester searching upward from rr, wrapping.
  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int i = (rr + k) % N;
      if (v[i]) return N'(1) << i;
    end
    return '0;
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic [5*N-1:0] rd, input logic [32*N-1:0] wd,
                       input string name, output logic [N-1:0] g);
    int gi;
    logic [4:0] rdi;
    bus.req_valid = v;
    bus.req_rd    = rd;
    bus.req_wd    = wd;
    @(negedge CLK);
    g = model_grant(v);
    check({name, "_ready"}, bus.req_ready, g);
    @(posedge CLK);
    if (g != '0) begin
      gi = 0;
      for (int k = 0; k < N; k++) if (g[k]) gi = k;
      rdi = rd[5*gi +: 5];
      if (rdi != 5'd0) begin
        exp_q.push_back('{rd: rdi, wd: wd[32*gi +: 32]});
        model_rf[rdi] = wd[32*gi +: 32];
      end
`ifndef RF_SCHED_FIXED_PRIO_EN
      rr = (gi + 1) % N;
`endif
    end
    #1;
  endtask

  // Called at posedge+1 just after RST has been released.
  task automatic run_init();
    for (int r = 1; r < 32; r++) begin
      logic [31:0] v = (r == 2 || r == 8) ? INIT_VAL : 32'd0;
      exp_q.push_back('{rd: 5'(r), wd: v});
      model_rf[r] = v;
    end
    rr = 0;
    for (int e = 1; e <= 31; e++) begin
      bus.req_valid = N'($urandom);
      bus.req_rd    = 15'($urandom);
      bus.req_wd    = {$urandom, $urandom, $urandom};
      @(negedge CLK);
      check("init_ready", bus.req_ready, '0);
      @(posedge CLK);
      #1;
      check("init_done", init_done, (e == 31));
    end
  endtask

  initial begin
    logic [N-1:0]    g;
    logic [N-1:0]    pv;
    logic [5*N-1:0]  prd;
    logic [32*N-1:0] pwd;

    for (int i = 0; i < 32; i++) begin
      rf_arr[i]   = '0;
      model_rf[i] = '0;
    end
    bus.req_valid = '1;
    bus.req_rd    = {5'd3, 5'd2, 5'd1};
    bus.req_wd    = '1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_we", rf_we, 0);
    check("rst_rd", rf_rd, 0);
    check("rst_wd", rf_wd, 0);
    check("rst_init_done", init_done, 0);
    check("rst_ready", bus.req_ready, '0);
    RST = 1'b0;
    run_init();

    // All three valid for six cycles.
    for (int c = 0; c < 6; c++)
      drive(3'b111, {5'd11, 5'd10, 5'd9}, {32'hC, 32'hB, 32'hA}, "all_valid", g);

    // Single write then read back from the regfile.
    drive(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, "single", g);
    drive(3'b000, '0, '0, "idle", g);
    check("x5_readback", rf_arr[5], 32'hDEADBEEF);

    // Write to x0 is consumed without a regfile write.
    drive(3'b010, '0, {32'h0, 32'h1234, 32'h0}, "rd0", g);
    for (int c = 0; c < 4; c++) drive(3'b000, '0, '0, "idle", g);
    check("idle_we", rf_we, 0);
    drive(3'b011, {5'd0, 5'd7, 5'd6}, {32'h0, 32'h77, 32'h66}, "wrap", g);
    check("wrap_grant", g, 3'b001);
    drive(3'b010, {5'd0, 5'd7, 5'd6}, {32'h0, 32'h77, 32'h66}, "wrap2", g);

    // Randomized traffic with requesters holding requests until granted.
    pv = '0; prd = '0; pwd = '0;
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i]           = 1'b1;
          prd[5*i +: 5]   = 5'($urandom_range(0, 31));
          pwd[32*i +: 32] = $urandom;
        end else if (pv[i] && $urandom_range(0, 7) == 0) begin
          pv[i] = 1'b0;
        end
      end
      drive(pv, prd, pwd, "rand", g);
      pv = pv & ~g;
    end

    // Reset in the middle of a run with everyone requesting.
    bus.req_valid = 3'b111;
    bus.req_rd    = {5'd21, 5'd20, 5'd19};
    bus.req_wd    = {32'h3, 32'h2, 32'h1};
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst_we", rf_we, 0);
    check("midrst_init_done", init_done, 0);
    check("midrst_ready", bus.req_ready, '0);
    RST = 1'b0;
    run_init();

    for (int c = 0; c < 20; c++) begin
      logic [N-1:0] v = N'($urandom);
      drive(v, 15'($urandom), {$urandom, $urandom, $urandom}, "post", g);
    end
    drive(3'b000, '0, '0, "flush", g);
    drive(3'b000, '0, '0, "flush", g);
    check("queue_drained", exp_q.size(), 0);
    for (int i = 0; i < 32; i++) check($sformatf("rf_x%0d", i), rf_arr[i], model_rf[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
